// File: rtl/lut_cfg_loader.sv
// Serial configuration loader for an 8-entry shift-register LUT.
// A parallel truth table is accepted over a valid/ready handshake and
// streamed MSB-first onto the LUT's S/enable pins. After a full load the
// LUT holds Q[i] = cfg_data[i], so it computes Z = cfg_data[{A,B,C}].
// S, enable and done are registered; cfg_ready and busy decode the state
// register only, so there is no combinational path from any input.

module lut_cfg_loader #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             hold,
  output logic             S,
  output logic             enable,
  output logic             busy,
  output logic             done
);

  // Counter widths: bits_left must represent WIDTH itself, gap_cnt must
  // represent GAP (at least one bit so the register always exists).
  localparam int BW = $clog2(WIDTH) + 1;
  localparam int GW = (GAP == 0) ? 1 : $clog2(GAP + 1);

  localparam logic [BW-1:0] BITS_FULL = BW'(WIDTH);
  localparam logic [BW-1:0] BITS_NEXT = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BITS_ONE  = BW'(1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP);
  localparam logic [GW-1:0] GAP_ONE   = GW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [BW-1:0]    bits_left_q, bits_left_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             s_q, s_d;
  logic             enable_q, enable_d;
  logic             done_q, done_d;

  // Next-state, datapath and registered-output decode for the streaming FSM.
  // The acceptance cycle doubles as the first shift cycle (unless held), so
  // the first enable appears in the cycle right after acceptance.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    bits_left_d = bits_left_q;
    gap_cnt_d   = gap_cnt_q;
    s_d         = 1'b0;
    enable_d    = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          state_d = ST_SHIFT;
          if (!hold) begin
            // Capture and emit the MSB in the same edge.
            s_d         = cfg_data[WIDTH-1];
            enable_d    = 1'b1;
            sreg_d      = {cfg_data[WIDTH-2:0], 1'b0};
            bits_left_d = BITS_NEXT;
            gap_cnt_d   = GAP_LOAD;
          end else begin
            // Capture only; the first bit goes out once hold releases.
            sreg_d      = cfg_data;
            bits_left_d = BITS_FULL;
            gap_cnt_d   = '0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (bits_left_q == '0) begin
          // Last bit is on the pins this cycle; done lines up with the
          // first cycle enable is low afterwards. hold cannot delay it.
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (hold) begin
          // Freeze position; enable is forced low next cycle.
          state_d = ST_SHIFT;
        end else if (gap_cnt_q == '0) begin
          s_d         = sreg_q[WIDTH-1];
          enable_d    = 1'b1;
          sreg_d      = {sreg_q[WIDTH-2:0], 1'b0};
          bits_left_d = bits_left_q - BITS_ONE;
          gap_cnt_d   = GAP_LOAD;
        end else begin
          // Idle spacing between shift pulses.
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d     = ST_IDLE;
        bits_left_d = '0;
        gap_cnt_d   = '0;
      end
    endcase
  end

  // State, shift register, counters and registered pin drivers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      sreg_q      <= '0;
      bits_left_q <= '0;
      gap_cnt_q   <= '0;
      s_q         <= 1'b0;
      enable_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      bits_left_q <= bits_left_d;
      gap_cnt_q   <= gap_cnt_d;
      s_q         <= s_d;
      enable_q    <= enable_d;
      done_q      <= done_d;
    end
  end

  assign S         = s_q;
  assign enable    = enable_q;
  assign done      = done_q;
  assign cfg_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Bench for lut_cfg_loader: two instances (GAP=0 and GAP=2) driven with
// directed and randomized loads. The reference model treats every posedge
// without hold as one tick of "unheld time" u; bit n leaves on the tick
// where u == n*(GAP+1). done follows the last bit by one cycle, ready by two.
// The LUT contents are rebuilt by shifting S on every enable cycle.

module tb_lut_cfg_loader;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            aresetn;
  logic [1:0]      valid, hold, rdy, s, en, busy, done;
  logic [1:0][W-1:0] data;
  logic [W-1:0]    lut;

  int n_chk  = 0;
  int n_pass = 0;

  lut_cfg_loader #(.WIDTH(W), .GAP(0)) u_dut0 (
    .clk(clk), .aresetn(aresetn), .cfg_valid(valid[0]), .cfg_ready(rdy[0]),
    .cfg_data(data[0]), .hold(hold[0]), .S(s[0]), .enable(en[0]),
    .busy(busy[0]), .done(done[0])
  );

  lut_cfg_loader #(.WIDTH(W), .GAP(2)) u_dut1 (
    .clk(clk), .aresetn(aresetn), .cfg_valid(valid[1]), .cfg_ready(rdy[1]),
    .cfg_data(data[1]), .hold(hold[1]), .S(s[1]), .enable(en[1]),
    .busy(busy[1]), .done(done[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_idle(input int d, input string tag);
    check({tag, "_en"},    32'(en[d]),   32'd0);
    check({tag, "_s"},     32'(s[d]),    32'd0);
    check({tag, "_done"},  32'(done[d]), 32'd0);
    check({tag, "_busy"},  32'(busy[d]), 32'd0);
    check({tag, "_ready"}, 32'(rdy[d]),  32'd1);
  endtask

  // One table load on instance d (gap g). hmode: 0 no hold, 1 random hold,
  // 2 hold for 5 cycles after the 3rd enable. abort_at>0: pulse reset after
  // that many enables and return.
  task automatic do_load(input int d, input int g, input logic [W-1:0] t,
                         input int hmode, input int abort_at, output logic [W-1:0] lut_o);
    int u, last, n_en, hold_left, idx;
    bit fin, cur_h, e_en, e_s, e_done, e_rdy;
    for (int i = 0; i < 50 && !rdy[d]; i++) @(negedge clk);
    check("ready_wait", 32'(rdy[d]), 32'd1);
    valid[d] = 1'b1;
    data[d]  = t;
    hold[d]  = (hmode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
    u = 0; last = -100; n_en = 0; hold_left = 0; fin = 1'b0;
    lut_o = '0;
    for (int c = 0; c < 200; c++) begin
      cur_h = hold[d];
      @(negedge clk);
      e_en = 1'b0;
      e_s  = 1'b0;
      if (!cur_h) begin
        idx = u / (g + 1);
        if ((u % (g + 1)) == 0 && idx < W) begin
          e_en = 1'b1;
          e_s  = t[W-1-idx];
          if (idx == W - 1) last = c;
        end
        u++;
      end
      e_done = (last >= 0) && (c == last + 1);
      e_rdy  = (last >= 0) && (c >= last + 2);
      check("enable", 32'(en[d]),   32'(e_en));
      check("S",      32'(s[d]),    32'(e_s));
      check("done",   32'(done[d]), 32'(e_done));
      check("ready",  32'(rdy[d]),  32'(e_rdy));
      check("busy",   32'(busy[d]), 32'(!e_rdy));
      if (en[d]) begin
        lut_o = {lut_o[W-2:0], s[d]};
        n_en++;
      end
      if (abort_at > 0 && n_en == abort_at) begin
        #2 aresetn = 1'b0;
        #1 check_idle(d, "rst_mid");
        @(negedge clk);
        aresetn  = 1'b1;
        valid[d] = 1'b0;
        hold[d]  = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("post_rst_done",  32'(done[d]), 32'd0);
          check("post_rst_ready", 32'(rdy[d]),  32'd1);
        end
        fin = 1'b1;
        break;
      end
      if (e_rdy) begin
        check("lut_contents", 32'(lut_o), 32'(t));
        check("enable_count", 32'(n_en),  32'(W));
        fin = 1'b1;
        break;
      end
      // Garbage on the handshake while busy must be ignored.
      valid[d] = 1'($urandom_range(0, 1));
      data[d]  = W'($urandom);
      if (hmode == 2 && en[d] && n_en == 3) hold_left = 5;
      if (hmode == 1) hold[d] = ($urandom_range(0, 3) == 0);
      else            hold[d] = (hold_left > 0);
      if (hold_left > 0) hold_left--;
    end
    valid[d] = 1'b0;
    hold[d]  = 1'b0;
    check("load_finished", 32'(fin), 32'd1);
  endtask

  initial begin
    aresetn = 1'b0;
    valid   = '0;
    hold    = '0;
    data    = '0;
    #12;
    check_idle(0, "reset0");
    check_idle(1, "reset1");
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);

    // Majority table: Z = 1 only where at least two of A,B,C are set.
    do_load(0, 0, 8'hE8, 0, 0, lut);
    for (int abc = 0; abc < 8; abc++)
      check("maj_z", 32'(lut[abc]), 32'($countones(abc) >= 2));

    // Back-to-back tables; second is offered the instant ready returns.
    do_load(0, 0, 8'h80, 0, 0, lut);
    for (int abc = 0; abc < 8; abc++)
      check("and_z", 32'(lut[abc]), 32'(abc == 7));
    do_load(0, 0, 8'h01, 0, 0, lut);

    // Hold window mid-table.
    do_load(0, 0, 8'hA5, 2, 0, lut);

    // Reset after the 4th enable, then a clean reload.
    do_load(0, 0, 8'hFF, 0, 4, lut);
    do_load(0, 0, 8'h0F, 0, 0, lut);

    // Spaced streaming on the GAP=2 instance.
    do_load(1, 2, 8'h55, 0, 0, lut);

    // Randomized tables and hold patterns on both instances.
    for (int i = 0; i < 12; i++)
      do_load(i % 2, (i % 2 == 1) ? 2 : 0, W'($urandom), int'($urandom_range(0, 2)), 0, lut);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
